// File: rtl/csc_upsample_unit_pkg.sv
// Shared types, CSC coefficients and default SRAM segment bases for the YUV->RGB decompression stage.
// Purely declarative plus two tiny arithmetic helpers; no latency or flow control of its own.
package csc_upsample_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_CALC,
        S_WR,
        S_DONE
    } csc_state_type;

    localparam logic signed [31:0] CSC_Y  = 32'sd76284;
    localparam logic signed [31:0] CSC_RV = 32'sd104595;
    localparam logic signed [31:0] CSC_GU = 32'sd25624;
    localparam logic signed [31:0] CSC_GV = 32'sd53281;
    localparam logic signed [31:0] CSC_BU = 32'sd132251;

    localparam logic [17:0] Y_BASE_DEF   = 18'd0;
    localparam logic [17:0] U_BASE_DEF   = 18'd38400;
    localparam logic [17:0] V_BASE_DEF   = 18'd57600;
    localparam logic [17:0] RGB_BASE_DEF = 18'd146944;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Rounded mean of two chroma samples; the 9-bit sum cannot overflow.
    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        return 8'(({1'b0, a} + {1'b0, b} + 9'd1) >> 1);
    endfunction

    function automatic logic [7:0] clip8(input logic signed [31:0] acc);
        logic signed [31:0] sh;
        sh = acc >>> 16;
        if (sh < 0) begin
            return 8'd0;
        end
        if (sh > 32'sd255) begin
            return 8'hFF;
        end
        return sh[7:0];
    endfunction

endpackage

// File: rtl/csc_upsample_unit_pixel.sv
// One-pixel YUV->RGB converter: fixed-point CSC followed by >>>16 and clip to 0..255.
// Purely combinational; no handshake.
module yuv2rgb_pixel
    import csc_upsample_unit_pkg::*;
(
    input  logic [7:0] y_i,
    input  logic [7:0] u_i,
    input  logic [7:0] v_i,
    output rgb_t       rgb_o
);

    logic signed [31:0] y_s;
    logic signed [31:0] u_s;
    logic signed [31:0] v_s;
    logic signed [31:0] r_acc;
    logic signed [31:0] g_acc;
    logic signed [31:0] b_acc;

    always_comb begin
        y_s   = $signed({24'd0, y_i}) - 32'sd16;
        u_s   = $signed({24'd0, u_i}) - 32'sd128;
        v_s   = $signed({24'd0, v_i}) - 32'sd128;
        r_acc = CSC_Y * y_s + CSC_RV * v_s;
        g_acc = CSC_Y * y_s - CSC_GU * u_s - CSC_GV * v_s;
        b_acc = CSC_Y * y_s + CSC_BU * u_s;
        rgb_o   = '0;
        rgb_o.r = clip8(r_acc);
        rgb_o.g = clip8(g_acc);
        rgb_o.b = clip8(b_acc);
    end

endmodule

// File: rtl/csc_upsample_unit.sv
// Frame decompressor: per 4-pixel group reads Y/U/V from SRAM, upsamples chroma 4:2:2->4:4:4, converts to RGB, writes back.
// Fixed 14+RD_LATENCY cycles per group; no backpressure, SRAM assumed always available.
module csc_upsample_unit
    import csc_upsample_unit_pkg::*;
#(
    parameter int          IMG_WIDTH  = 320,
    parameter int          IMG_HEIGHT = 240,
    parameter logic [17:0] Y_BASE     = Y_BASE_DEF,
    parameter logic [17:0] U_BASE     = U_BASE_DEF,
    parameter logic [17:0] V_BASE     = V_BASE_DEF,
    parameter logic [17:0] RGB_BASE   = RGB_BASE_DEF,
    parameter int          RD_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [17:0] sram_address_o,
    output logic [15:0] sram_write_data_o,
    output logic        sram_we_n_o,
    input  logic [15:0] sram_read_data_i
);

    localparam int NUM_GRP     = IMG_WIDTH * IMG_HEIGHT / 4;
    localparam int GRP_PER_ROW = IMG_WIDTH / 4;
    localparam int GW          = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam int CW          = (GRP_PER_ROW > 1) ? $clog2(GRP_PER_ROW) : 1;

    csc_state_type         state_q, state_d;
    logic [2:0]            step_q, step_d;
    logic [GW-1:0]         grp_q, grp_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RD_LATENCY-1:0] rd_pipe_q;
    logic [2:0]            cap_idx_q;
    logic [15:0]           y01_q, y23_q, u01_q, v01_q;
    logic [7:0]            u2_q, v2_q;
    rgb_t [3:0]            pix_q;
    rgb_t                  pix_a, pix_b;
    logic [7:0]            ya, ua, va, yb, ub, vb;
    logic                  row_end, last_grp;
    logic [17:0]           grp_addr;

    assign row_end  = (col_q == CW'(GRP_PER_ROW - 1));
    assign last_grp = (grp_q == GW'(NUM_GRP - 1));
    assign grp_addr = 18'(grp_q);
    assign busy_o   = state_q inside {S_RD, S_WAIT, S_CALC, S_WR};
    assign done_o   = (state_q == S_DONE);

    // CALC step 0 produces pixels 0/1, step 1 pixels 2/3; the row's last odd pixel replicates its own chroma.
    always_comb begin
        if (!step_q[0]) begin
            ya = y01_q[15:8];
            ua = u01_q[15:8];
            va = v01_q[15:8];
            yb = y01_q[7:0];
            ub = avg8(u01_q[15:8], u01_q[7:0]);
            vb = avg8(v01_q[15:8], v01_q[7:0]);
        end else begin
            ya = y23_q[15:8];
            ua = u01_q[7:0];
            va = v01_q[7:0];
            yb = y23_q[7:0];
            ub = row_end ? u01_q[7:0] : avg8(u01_q[7:0], u2_q);
            vb = row_end ? v01_q[7:0] : avg8(v01_q[7:0], v2_q);
        end
    end

    yuv2rgb_pixel u_pix_a (.y_i(ya), .u_i(ua), .v_i(va), .rgb_o(pix_a));
    yuv2rgb_pixel u_pix_b (.y_i(yb), .u_i(ub), .v_i(vb), .rgb_o(pix_b));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            grp_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            grp_q   <= grp_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        step_d            = step_q;
        grp_d             = grp_q;
        col_d             = col_q;
        sram_address_o    = '0;
        sram_write_data_o = '0;
        sram_we_n_o       = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RD;
                    step_d  = '0;
                end
            end
            S_RD: begin
                case (step_q)
                    3'd0:    sram_address_o = Y_BASE + (grp_addr << 1);
                    3'd1:    sram_address_o = Y_BASE + (grp_addr << 1) + 18'd1;
                    3'd2:    sram_address_o = U_BASE + grp_addr;
                    3'd3:    sram_address_o = U_BASE + grp_addr + 18'd1;
                    3'd4:    sram_address_o = V_BASE + grp_addr;
                    default: sram_address_o = V_BASE + grp_addr + 18'd1;
                endcase
                if (step_q == 3'd5) begin
                    state_d = S_WAIT;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_WAIT: begin
                if (step_q == 3'(RD_LATENCY - 1)) begin
                    state_d = S_CALC;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_CALC: begin
                if (step_q == 3'd1) begin
                    state_d = S_WR;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_WR: begin
                sram_we_n_o    = 1'b0;
                sram_address_o = RGB_BASE + grp_addr * 18'd6 + 18'(step_q);
                case (step_q)
                    3'd0:    sram_write_data_o = {pix_q[0].r, pix_q[0].g};
                    3'd1:    sram_write_data_o = {pix_q[0].b, pix_q[1].r};
                    3'd2:    sram_write_data_o = {pix_q[1].g, pix_q[1].b};
                    3'd3:    sram_write_data_o = {pix_q[2].r, pix_q[2].g};
                    3'd4:    sram_write_data_o = {pix_q[2].b, pix_q[3].r};
                    default: sram_write_data_o = {pix_q[3].g, pix_q[3].b};
                endcase
                if (step_q == 3'd5) begin
                    state_d = last_grp ? S_DONE : S_RD;
                    step_d  = '0;
                    grp_d   = grp_q + GW'(1);
                    col_d   = row_end ? '0 : col_q + CW'(1);
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                step_d  = '0;
                grp_d   = '0;
                col_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Each read's data arrives RD_LATENCY cycles after its address; capture order mirrors issue order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_pipe_q <= '0;
            cap_idx_q <= '0;
            y01_q     <= '0;
            y23_q     <= '0;
            u01_q     <= '0;
            v01_q     <= '0;
            u2_q      <= '0;
            v2_q      <= '0;
            pix_q     <= '0;
        end else begin
            rd_pipe_q <= RD_LATENCY'({rd_pipe_q, state_q == S_RD});
            if (rd_pipe_q[RD_LATENCY-1]) begin
                cap_idx_q <= (cap_idx_q == 3'd5) ? 3'd0 : cap_idx_q + 3'd1;
                case (cap_idx_q)
                    3'd0:    y01_q <= sram_read_data_i;
                    3'd1:    y23_q <= sram_read_data_i;
                    3'd2:    u01_q <= sram_read_data_i;
                    3'd3:    u2_q  <= sram_read_data_i[15:8];
                    3'd4:    v01_q <= sram_read_data_i;
                    default: v2_q  <= sram_read_data_i[15:8];
                endcase
            end
            if (state_q == S_CALC) begin
                if (!step_q[0]) begin
                    pix_q[0] <= pix_a;
                    pix_q[1] <= pix_b;
                end else begin
                    pix_q[2] <= pix_a;
                    pix_q[3] <= pix_b;
                end
            end
        end
    end

endmodule
